// File: rtl/wb_sram_bridge_if.sv
// Wishbone B4 classic bus bundle between a bus master and the wb_sram_bridge slave.
interface wb_sram_bridge_if;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        wb_err_o;

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
    input  wb_dat_o, wb_ack_o, wb_err_o
  );

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
    output wb_dat_o, wb_ack_o, wb_err_o
  );
endinterface

// File: rtl/wb_sram_bridge.sv
// Wishbone classic slave to byte-serial SRAM controller bridge: decode, range check,
// read-modify-write for partial writes and a completion timeout. All outputs registered.
module wb_sram_bridge #(
  parameter logic [31:0] ADDR_BASE  = 32'h0000_0000,
  parameter int unsigned SRAM_BYTES = 131072,
  parameter int unsigned TIMEOUT    = 64          // must be >= 8
) (
  input  logic                   clk,
  input  logic                   rst,
  wb_sram_bridge_if.slave        wb,
  output logic [31:0]            s_addr,
  output logic [31:0]            s_wdata,
  output logic                   s_we,
  output logic                   s_access,
  input  logic [31:0]            s_rdata,
  input  logic                   sram_wr_finish
);

  localparam int unsigned        CNT_W    = $clog2(TIMEOUT);
  localparam logic [31:0]        LAST_OFF = 32'(SRAM_BYTES - 4);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, CHECK, RD, WR, RESP} state_t;

  state_t             state_q, state_d;
  logic [31:0]        adr_q, adr_d;
  logic [31:0]        dat_q, dat_d;
  logic [3:0]         sel_q, sel_d;
  logic               we_q, we_d;
  logic               rmw_q, rmw_d;
  logic               abort_q, abort_d;
  logic               resp_err_q, resp_err_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        s_addr_q, s_addr_d;
  logic [31:0]        s_wdata_q, s_wdata_d;
  logic               s_we_q, s_we_d;
  logic               s_access_q, s_access_d;
  logic               ack_q, ack_d;
  logic               err_q, err_d;
  logic [31:0]        wb_dat_q, wb_dat_d;

  logic               bus_req;
  logic               fin;
  logic               timed_out;
  logic [31:0]        off;
  logic [31:0]        merged;

  assign bus_req   = wb.wb_cyc_i & wb.wb_stb_i;
  // A finish pulse only counts while a request is actually outstanding.
  assign fin       = sram_wr_finish & s_access_q;
  assign timed_out = (cnt_q == CNT_LAST);
  assign off       = adr_q - ADDR_BASE;

  always_comb begin
    merged = '0;
    for (int i = 0; i < 4; i++)
      merged[8*i +: 8] = sel_q[i] ? dat_q[8*i +: 8] : s_rdata[8*i +: 8];
  end

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    sel_d      = sel_q;
    we_d       = we_q;
    rmw_d      = rmw_q;
    abort_d    = abort_q;
    resp_err_d = resp_err_q;
    rdata_d    = rdata_q;
    cnt_d      = cnt_q;
    s_addr_d   = s_addr_q;
    s_wdata_d  = s_wdata_q;
    s_access_d = 1'b0;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    wb_dat_d   = '0;

    if ((state_q == CHECK || state_q == RD || state_q == WR) && !bus_req)
      abort_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (bus_req && !ack_q && !err_q) begin
          adr_d   = wb.wb_adr_i;
          dat_d   = wb.wb_dat_i;
          sel_d   = wb.wb_sel_i;
          we_d    = wb.wb_we_i;
          rmw_d   = 1'b0;
          abort_d = 1'b0;
          state_d = CHECK;
        end
      end

      CHECK: begin
        if (adr_q[1:0] != 2'b00 || off > LAST_OFF) begin
          resp_err_d = 1'b1;
          state_d    = RESP;
        end else if (we_q && sel_q == 4'h0) begin
          resp_err_d = 1'b0;
          rdata_d    = '0;
          state_d    = RESP;
        end else begin
          resp_err_d = 1'b0;
          s_addr_d   = off;
          s_wdata_d  = dat_q;
          cnt_d      = '0;
          s_access_d = 1'b1;
          if (we_q && sel_q == 4'hF) begin
            state_d = WR;
          end else begin
            rmw_d   = we_q;
            state_d = RD;
          end
        end
      end

      RD: begin
        cnt_d      = cnt_q + CNT_W'(1);
        s_access_d = 1'b1;
        if (fin) begin
          s_access_d = 1'b0;
          if (rmw_q) begin
            // WR entry leaves s_access low for one cycle before the write launches.
            s_wdata_d = merged;
            cnt_d     = '0;
            state_d   = WR;
          end else begin
            rdata_d = s_rdata;
            state_d = RESP;
          end
        end else if (timed_out) begin
          s_access_d = 1'b0;
          resp_err_d = 1'b1;
          state_d    = RESP;
        end
      end

      WR: begin
        cnt_d      = cnt_q + CNT_W'(1);
        s_access_d = 1'b1;
        if (fin) begin
          s_access_d = 1'b0;
          rdata_d    = '0;
          state_d    = RESP;
        end else if (timed_out) begin
          s_access_d = 1'b0;
          resp_err_d = 1'b1;
          state_d    = RESP;
        end
      end

      RESP: begin
        ack_d    = !resp_err_q;
        err_d    = resp_err_q;
        wb_dat_d = resp_err_q ? 32'h0 : rdata_q;
        state_d  = IDLE;
      end

      default: state_d = IDLE;
    endcase

    // An abandoned bus cycle still finishes its SRAM work but gets no response pulse.
    if (state_q != RESP && state_d == RESP && (abort_q || !bus_req))
      state_d = IDLE;

    s_we_d = (state_d == WR);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    // NOTE: reset clears every register, including the data path, so outputs are all-zero after reset.
    if (rst) begin
      state_q    <= IDLE;
      adr_q      <= '0;
      dat_q      <= '0;
      sel_q      <= '0;
      we_q       <= 1'b0;
      rmw_q      <= 1'b0;
      abort_q    <= 1'b0;
      resp_err_q <= 1'b0;
      rdata_q    <= '0;
      cnt_q      <= '0;
      s_addr_q   <= '0;
      s_wdata_q  <= '0;
      s_we_q     <= 1'b0;
      s_access_q <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      wb_dat_q   <= '0;
    end else begin
      state_q    <= state_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      sel_q      <= sel_d;
      we_q       <= we_d;
      rmw_q      <= rmw_d;
      abort_q    <= abort_d;
      resp_err_q <= resp_err_d;
      rdata_q    <= rdata_d;
      cnt_q      <= cnt_d;
      s_addr_q   <= s_addr_d;
      s_wdata_q  <= s_wdata_d;
      s_we_q     <= s_we_d;
      s_access_q <= s_access_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      wb_dat_q   <= wb_dat_d;
    end
  end

  assign s_addr      = s_addr_q;
  assign s_wdata     = s_wdata_q;
  assign s_we        = s_we_q;
  assign s_access    = s_access_q;
  assign wb.wb_ack_o = ack_q;
  assign wb.wb_err_o = err_q;
  assign wb.wb_dat_o = wb_dat_q;

endmodule

// File: tb/tb_wb_sram_bridge.sv
// Self-checking bench for wb_sram_bridge: directed bus steps plus randomized transfers
// scored against a word-array memory model and a simple SRAM controller model.
module tb_wb_sram_bridge;

  localparam logic [31:0] BASE       = 32'h4000_0000;
  localparam int unsigned SRAM_BYTES = 131072;
  localparam int unsigned TIMEOUT    = 16;
  localparam int          SRAM_WORDS = SRAM_BYTES / 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] s_addr, s_wdata;
  logic        s_we, s_access;
  logic [31:0] s_rdata = '0;
  logic        sram_wr_finish = 1'b0;

  wb_sram_bridge_if bus ();

  wb_sram_bridge #(
    .ADDR_BASE (BASE),
    .SRAM_BYTES(SRAM_BYTES),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .wb            (bus),
    .s_addr        (s_addr),
    .s_wdata       (s_wdata),
    .s_we          (s_we),
    .s_access      (s_access),
    .s_rdata       (s_rdata),
    .sram_wr_finish(sram_wr_finish)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // SRAM controller model: finishes ctrl_lat cycles after it sees s_access, unless hung.
  logic [31:0] sram    [SRAM_WORDS] = '{default: '0};
  logic [31:0] ref_mem [SRAM_WORDS] = '{default: '0};
  int          ctrl_lat   = 2;
  logic        hang       = 1'b0;
  int          lat_cnt    = 0;
  int          n_rd_ops   = 0;
  int          n_wr_ops   = 0;
  logic [31:0] last_addr  = '0;
  logic [31:0] last_wdata = '0;

  always @(posedge clk) begin
    sram_wr_finish <= 1'b0;
    if (rst) begin
      lat_cnt <= 0;
    end else if (s_access && !sram_wr_finish && !hang) begin
      if (lat_cnt >= ctrl_lat - 1) begin
        sram_wr_finish <= 1'b1;
        lat_cnt        <= 0;
        last_addr      <= s_addr;
        if (s_we) begin
          sram[s_addr[16:2]] <= s_wdata;
          last_wdata         <= s_wdata;
          n_wr_ops           <= n_wr_ops + 1;
        end else begin
          s_rdata  <= sram[s_addr[16:2]];
          n_rd_ops <= n_rd_ops + 1;
        end
      end else begin
        lat_cnt <= lat_cnt + 1;
      end
    end else begin
      lat_cnt <= 0;
    end
  end

  // Activity monitor, sampled on the falling edge.
  int   access_cycles = 0;
  int   n_launch      = 0;
  int   low_run       = 0;
  int   last_gap      = 0;
  int   double_ack    = 0;
  int   both_high     = 0;
  logic prev_acc      = 1'b0;
  logic prev_ack      = 1'b0;

  always @(negedge clk) begin
    if (s_access) begin
      access_cycles++;
      if (!prev_acc) begin
        n_launch++;
        last_gap = low_run;
      end
      low_run = 0;
    end else begin
      low_run++;
    end
    prev_acc = s_access;
    if (bus.wb_ack_o && prev_ack) double_ack++;
    if (bus.wb_ack_o && bus.wb_err_o) both_high++;
    prev_ack = bus.wb_ack_o;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_error(input logic [31:0] adr);
    logic [31:0] o;
    o = adr - BASE;
    return (adr[1:0] != 2'b00) || (o > 32'(SRAM_BYTES - 4));
  endfunction

  task automatic ref_write(input logic [31:0] off, input logic [31:0] dat, input logic [3:0] sel);
    for (int b = 0; b < 4; b++)
      if (sel[b]) ref_mem[off[16:2]][8*b +: 8] = dat[8*b +: 8];
  endtask

  task automatic drive(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel);
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    bus.wb_we_i  = we;
    bus.wb_adr_i = adr;
    bus.wb_dat_i = dat;
    bus.wb_sel_i = sel;
  endtask

  task automatic release_bus();
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
  endtask

  // One bus transfer; lat counts clock edges after the accepting edge until ack/err is seen.
  task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, output logic ga, output logic ge,
                      output logic [31:0] rd, output int lat);
    logic done;
    ga = 1'b0; ge = 1'b0; rd = '0; lat = -1; done = 1'b0;
    @(negedge clk);
    drive(we, adr, dat, sel);
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (bus.wb_ack_o || bus.wb_err_o) begin
        ga = bus.wb_ack_o; ge = bus.wb_err_o; rd = bus.wb_dat_o; lat = i; done = 1'b1;
      end
    end
    release_bus();
  endtask

  initial begin
    logic        ga, ge, we;
    logic [31:0] rd, adr, off, dat;
    logic [3:0]  sel;
    int          lat, rd0, wr0, acc0, launch0, dbl0, resp_seen, acks, cls;

    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
    bus.wb_adr_i = '0;   bus.wb_dat_i = '0;   bus.wb_sel_i = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ack",     32'(bus.wb_ack_o), 32'd0);
    check("rst_err",     32'(bus.wb_err_o), 32'd0);
    check("rst_access",  32'(s_access),     32'd0);
    check("rst_we",      32'(s_we),         32'd0);
    check("rst_dat_o",   bus.wb_dat_o,      32'd0);
    check("rst_s_addr",  s_addr,            32'd0);
    check("rst_s_wdata", s_wdata,           32'd0);
    rst = 1'b0;

    // Full-word write then read back
    ctrl_lat = 3;
    rd0 = n_rd_ops; wr0 = n_wr_ops;
    xfer(1'b1, BASE + 32'h100, 32'hDEAD_BEEF, 4'hF, ga, ge, rd, lat);
    ref_write(32'h100, 32'hDEAD_BEEF, 4'hF);
    check("wr_ack",    32'({ga, ge}), 32'b10);
    check("wr_ops",    32'(n_wr_ops - wr0), 32'd1);
    check("wr_no_rd",  32'(n_rd_ops - rd0), 32'd0);
    check("wr_addr",   last_addr,  32'h100);
    check("wr_wdata",  last_wdata, 32'hDEAD_BEEF);
    xfer(1'b0, BASE + 32'h100, 32'h0, 4'hF, ga, ge, rd, lat);
    check("rd_ack",    32'({ga, ge}), 32'b10);
    check("rd_data",   rd, 32'hDEAD_BEEF);
    check("rd_ops",    32'(n_rd_ops - rd0), 32'd1);

    // Partial write by read-modify-write
    xfer(1'b1, BASE + 32'h200, 32'h1122_3344, 4'hF, ga, ge, rd, lat);
    ref_write(32'h200, 32'h1122_3344, 4'hF);
    rd0 = n_rd_ops; wr0 = n_wr_ops; launch0 = n_launch;
    xfer(1'b1, BASE + 32'h200, 32'h0000_AA00, 4'b0010, ga, ge, rd, lat);
    ref_write(32'h200, 32'h0000_AA00, 4'b0010);
    check("rmw_ack",     32'({ga, ge}), 32'b10);
    check("rmw_rd_ops",  32'(n_rd_ops - rd0), 32'd1);
    check("rmw_wr_ops",  32'(n_wr_ops - wr0), 32'd1);
    check("rmw_launch",  32'(n_launch - launch0), 32'd2);
    check("rmw_gap",     32'(last_gap), 32'd1);
    check("rmw_wdata",   last_wdata, 32'h1122_AA44);
    xfer(1'b0, BASE + 32'h200, 32'h0, 4'hF, ga, ge, rd, lat);
    check("rmw_readback", rd, 32'h1122_AA44);

    // Alignment and range errors
    acc0 = access_cycles;
    xfer(1'b1, BASE + 32'h2, 32'h1234_5678, 4'hF, ga, ge, rd, lat);
    check("misalign_err",  32'({ga, ge}), 32'b01);
    check("misalign_lat",  32'(lat), 32'd2);
    check("misalign_noacc", 32'(access_cycles - acc0), 32'd0);
    xfer(1'b0, BASE + SRAM_BYTES - 4, 32'h0, 4'hF, ga, ge, rd, lat);
    check("top_word_ack",  32'({ga, ge}), 32'b10);
    check("top_word_data", rd, ref_mem[SRAM_WORDS-1]);
    acc0 = access_cycles;
    xfer(1'b0, BASE + SRAM_BYTES, 32'h0, 4'hF, ga, ge, rd, lat);
    check("past_end_err",  32'({ga, ge}), 32'b01);
    xfer(1'b0, BASE - 32'd4, 32'h0, 4'hF, ga, ge, rd, lat);
    check("wrap_err",      32'({ga, ge}), 32'b01);
    check("range_noacc",   32'(access_cycles - acc0), 32'd0);

    // Zero byte-select write
    acc0 = access_cycles;
    xfer(1'b1, BASE + 32'h100, 32'hFFFF_FFFF, 4'h0, ga, ge, rd, lat);
    check("sel0_ack",   32'({ga, ge}), 32'b10);
    check("sel0_lat",   32'(lat), 32'd2);
    check("sel0_noacc", 32'(access_cycles - acc0), 32'd0);

    // Controller never finishes
    hang = 1'b1; acc0 = access_cycles;
    xfer(1'b0, BASE + 32'h100, 32'h0, 4'hF, ga, ge, rd, lat);
    check("tmo_err",     32'({ga, ge}), 32'b01);
    check("tmo_lat",     32'(lat), 32'(TIMEOUT + 2));
    check("tmo_acc_low", 32'(s_access), 32'd0);
    check("tmo_had_acc", 32'(access_cycles - acc0 > 0), 32'd1);
    hang = 1'b0;
    xfer(1'b0, BASE + 32'h100, 32'h0, 4'hF, ga, ge, rd, lat);
    check("post_tmo_ack",  32'({ga, ge}), 32'b10);
    check("post_tmo_data", rd, 32'hDEAD_BEEF);

    // Bus cycle abandoned in the middle of a read-modify-write
    xfer(1'b1, BASE + 32'h300, 32'hA5A5_A5A5, 4'hF, ga, ge, rd, lat);
    ref_write(32'h300, 32'hA5A5_A5A5, 4'hF);
    rd0 = n_rd_ops; wr0 = n_wr_ops; resp_seen = 0;
    @(negedge clk);
    drive(1'b1, BASE + 32'h300, 32'h1100_0022, 4'b1001);
    repeat (2) @(negedge clk);
    release_bus();
    repeat (60) begin
      @(negedge clk);
      if (bus.wb_ack_o || bus.wb_err_o) resp_seen++;
    end
    ref_write(32'h300, 32'h1100_0022, 4'b1001);
    check("abort_no_resp", 32'(resp_seen), 32'd0);
    check("abort_rd_ops",  32'(n_rd_ops - rd0), 32'd1);
    check("abort_wr_ops",  32'(n_wr_ops - wr0), 32'd1);
    check("abort_wdata",   last_wdata, 32'h11A5_A522);
    xfer(1'b0, BASE + 32'h300, 32'h0, 4'hF, ga, ge, rd, lat);
    check("abort_readback", rd, ref_mem[32'h300 >> 2]);

    // Reset while a read is outstanding
    ctrl_lat = 10;
    @(negedge clk);
    drive(1'b0, BASE + 32'h100, 32'h0, 4'hF);
    repeat (4) @(negedge clk);
    check("mid_rd_access", 32'(s_access), 32'd1);
    rst = 1'b1;
    release_bus();
    @(negedge clk);
    check("mid_rst_access", 32'(s_access),     32'd0);
    check("mid_rst_we",     32'(s_we),         32'd0);
    check("mid_rst_ack",    32'(bus.wb_ack_o), 32'd0);
    check("mid_rst_err",    32'(bus.wb_err_o), 32'd0);
    check("mid_rst_addr",   s_addr,            32'd0);
    check("mid_rst_dat_o",  bus.wb_dat_o,      32'd0);
    rst = 1'b0;
    ctrl_lat = 2;
    xfer(1'b0, BASE + 32'h1, 32'h0, 4'hF, ga, ge, rd, lat);
    check("post_rst_idle", 32'(lat), 32'd2);

    // Two reads with strobe held throughout
    rd0 = n_rd_ops; dbl0 = double_ack; acks = 0;
    @(negedge clk);
    drive(1'b0, BASE + 32'h100, 32'h0, 4'hF);
    for (int i = 0; i < 200 && acks < 2; i++) begin
      @(negedge clk);
      if (bus.wb_ack_o) begin
        acks++;
        check("b2b_data", bus.wb_dat_o, 32'hDEAD_BEEF);
      end
    end
    release_bus();
    repeat (10) @(negedge clk);
    check("b2b_acks",   32'(acks), 32'd2);
    check("b2b_rd_ops", 32'(n_rd_ops - rd0), 32'd2);
    check("b2b_gap",    32'(double_ack - dbl0), 32'd0);

    // Randomized transfers against the memory model
    for (int k = 0; k < 48; k++) begin
      ctrl_lat = int'($urandom_range(1, 4));
      cls = int'($urandom_range(0, 5));
      case (cls)
        0, 1, 2: off = 32'($urandom_range(0, 15)) << 2;
        3:       off = 32'(SRAM_BYTES) - (32'($urandom_range(1, 4)) << 2);
        4:       off = (32'($urandom_range(0, 15)) << 2) + 32'($urandom_range(1, 3));
        default: off = ($urandom_range(0, 1) == 1) ?
                       32'(SRAM_BYTES) + (32'($urandom_range(0, 3)) << 2) :
                       32'h0 - (32'($urandom_range(1, 3)) << 2);
      endcase
      adr = BASE + off;
      we  = 1'($urandom_range(0, 1));
      sel = 4'($urandom_range(0, 15));
      dat = $urandom();
      xfer(we, adr, dat, sel, ga, ge, rd, lat);
      if (exp_error(adr)) begin
        check("rnd_err", 32'({ga, ge}), 32'b01);
      end else begin
        check("rnd_ack", 32'({ga, ge}), 32'b10);
        if (we) begin
          check("rnd_wr_dat_o", rd, 32'd0);
          ref_write(off, dat, sel);
        end else begin
          check("rnd_rdata", rd, ref_mem[off[16:2]]);
        end
      end
    end

    check("never_ack_and_err", 32'(both_high), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
